// File: rtl/symbol_upsampler.sv
// Symbol-to-sample converter: takes symbols over valid/ready and emits a fixed-rate I/Q
// sample stream with a per-symbol strobe, symbol boundaries placed by an NCO phase accumulator.
module symbol_upsampler #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ZERO_STUFF,
    input  logic [7:0]       DRIFT,
    input  logic [WIDTH-1:0] I_1M,
    input  logic [WIDTH-1:0] Q_1M,
    input  logic             sym_valid,
    output logic             sym_ready,
    output logic [WIDTH-1:0] I_32M,
    output logic [WIDTH-1:0] Q_32M,
    output logic             sym_strobe,
    output logic             underrun
);

    // Symbol period and nominal per-sample phase step, in accumulator units.
    localparam logic [WIDTH-1:0] PERIOD = {3'b001, {(WIDTH-3){1'b0}}};
    localparam logic [WIDTH-1:0] NOM    = {8'b0000_0001, {(WIDTH-8){1'b0}}};

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sym_i_q, sym_i_d;
    logic [WIDTH-1:0] sym_q_q, sym_q_d;
    logic [WIDTH-1:0] i_out_q, i_out_d;
    logic [WIDTH-1:0] q_out_q, q_out_d;
    logic             strobe_q, strobe_d;
    logic             underrun_q, underrun_d;

    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] phase_sum;
    logic             boundary;
    logic             take;

    // Step stays positive for any DRIFT, and cnt stays below PERIOD, so the sum never wraps.
    assign step      = NOM + {{(WIDTH-8){DRIFT[7]}}, DRIFT};
    assign phase_sum = cnt_q + step;
    assign boundary  = (state_q == RUN) && (phase_sum >= PERIOD);
    assign take      = sym_ready && sym_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sym_i_q    <= '0;
            sym_q_q    <= '0;
            i_out_q    <= '0;
            q_out_q    <= '0;
            strobe_q   <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sym_i_q    <= sym_i_d;
            sym_q_q    <= sym_q_d;
            i_out_q    <= i_out_d;
            q_out_q    <= q_out_d;
            strobe_q   <= strobe_d;
            underrun_q <= underrun_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sym_valid) state_d = RUN;
            RUN:     if (boundary && !sym_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sym_ready  = (state_q == IDLE) || boundary;
        cnt_d      = cnt_q;
        sym_i_d    = sym_i_q;
        sym_q_d    = sym_q_q;
        i_out_d    = '0;
        q_out_d    = '0;
        strobe_d   = 1'b0;
        underrun_d = underrun_q;
        if (take) begin
            sym_i_d  = I_1M;
            sym_q_d  = Q_1M;
            i_out_d  = I_1M;
            q_out_d  = Q_1M;
            strobe_d = 1'b1;
            // Keep the fractional phase across boundaries so drift averages out exactly.
            cnt_d    = (state_q == IDLE) ? '0 : phase_sum - PERIOD;
        end else if (boundary) begin
            underrun_d = 1'b1;
            cnt_d      = '0;
        end else if (state_q == RUN) begin
            cnt_d = phase_sum;
            if (!ZERO_STUFF) begin
                i_out_d = sym_i_q;
                q_out_d = sym_q_q;
            end
        end
    end

    assign I_32M      = i_out_q;
    assign Q_32M      = q_out_q;
    assign sym_strobe = strobe_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_symbol_upsampler.sv
// Scoreboard bench for symbol_upsampler: the driver queues each accepted symbol's expected
// samples, and a negedge monitor checks strobes, held/zeroed samples, intervals and ready pulses.
module tb_symbol_upsampler;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         zs = 1'b0;
    logic [7:0]   drift = 8'd0;
    logic [W-1:0] i_in = '0;
    logic [W-1:0] q_in = '0;
    logic         valid = 1'b0;
    logic         ready;
    logic [W-1:0] i_out;
    logic [W-1:0] q_out;
    logic         strobe;
    logic         und;

    symbol_upsampler #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .ZERO_STUFF (zs),
        .DRIFT      (drift),
        .I_1M       (i_in),
        .Q_1M       (q_in),
        .sym_valid  (valid),
        .sym_ready  (ready),
        .I_32M      (i_out),
        .Q_32M      (q_out),
        .sym_strobe (strobe),
        .underrun   (und)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] i;
        logic [W-1:0] q;
        int           t;
    } exp_t;

    exp_t sb[$];
    int   st_times[$];
    int   total = 0;
    int   bad = 0;

    bit   chk_hold = 0;
    bit   chk_ready = 0;
    bit   chk_period = 0;
    int   per_lo = 32;
    int   per_hi = 32;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
        end
    endtask

    // Monitor
    initial begin
        logic [W-1:0] cur_i = '0;
        logic [W-1:0] cur_q = '0;
        bit           prev_ready = 0;
        int           last_t = 0;
        bit           last_ok = 0;
        exp_t         e;
        forever begin
            @(negedge clk);
            if (rst) begin
                cur_i      = '0;
                cur_q      = '0;
                prev_ready = 0;
                last_ok    = 0;
            end else begin
                if (strobe) begin
                    st_times.push_back(cyc);
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL strobe_unexpected: got strobe with empty scoreboard, expected none (cycle %0d)", cyc);
                    end else begin
                        e = sb.pop_front();
                        check("I_strobe", i_out, e.i);
                        check("Q_strobe", q_out, e.q);
                        check("latency", cyc, e.t + 1);
                        cur_i = e.i;
                        cur_q = e.q;
                    end
                    if (chk_period && last_ok) check_rng("interval", cyc - last_t, per_lo, per_hi);
                    last_t  = cyc;
                    last_ok = chk_period;
                end else if (chk_hold) begin
                    check("I_between", i_out, zs ? '0 : cur_i);
                    check("Q_between", q_out, zs ? '0 : cur_q);
                end
                if (chk_ready) check("ready_before_strobe", prev_ready, strobe);
                prev_ready = ready;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst   = 1'b1;
        valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Presents n symbols alternating I=0x1000/0xF000 with Q=-I; call at posedge+#1.
    task automatic run_syms(input int n, input int max_cyc);
        int           k = 0;
        int           c = 0;
        bit           acc;
        logic [W-1:0] a = 16'h1000;
        exp_t         e;
        valid = 1'b1;
        i_in  = a;
        q_in  = 16'hF000;
        while (k < n && c < max_cyc) begin
            @(negedge clk);
            c++;
            acc = ready;
            if (acc) begin
                e.i = a;
                e.q = (a == 16'h1000) ? 16'hF000 : 16'h1000;
                e.t = cyc;
                sb.push_back(e);
                k++;
            end
            @(posedge clk);
            #1;
            if (acc) begin
                a    = (a == 16'h1000) ? 16'hF000 : 16'h1000;
                i_in = a;
                q_in = (a == 16'h1000) ? 16'hF000 : 16'h1000;
            end
            if (k == n) valid = 1'b0;
        end
        valid = 1'b0;
        if (k < n) check_rng("accept_timeout", k, n, n);
    endtask

    task automatic run_phase(input bit zs_v, input logic [7:0] drift_v, input int n,
                             input int lo, input int hi, input int span_lo, input int span_hi);
        int base;
        zs    = zs_v;
        drift = drift_v;
        do_reset();
        per_lo     = lo;
        per_hi     = hi;
        chk_hold   = 1;
        chk_ready  = 1;
        chk_period = 1;
        base       = st_times.size();
        run_syms(n, n * 40 + 10);
        @(negedge clk);
        @(posedge clk);
        #1;
        chk_hold   = 0;
        chk_ready  = 0;
        chk_period = 0;
        check("sb_empty", sb.size(), 0);
        check("underrun_clear", und, 1'b0);
        if (span_hi > 0) begin
            if (st_times.size() >= base + n)
                check_rng("span", st_times[base + n - 1] - st_times[base], span_lo, span_hi);
            else
                check_rng("strobe_count", st_times.size() - base, n, n);
        end
        $display("phase zs=%0d drift=%0d symbols=%0d done at cycle %0d", zs_v, $signed(drift_v), n, cyc);
    endtask

    initial begin
        // Idle after reset: everything quiet, ready high.
        do_reset();
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            check("idle_I", i_out, '0);
            check("idle_Q", q_out, '0);
            check("idle_strobe", strobe, 1'b0);
            check("idle_ready", ready, 1'b1);
            check("idle_underrun", und, 1'b0);
        end

        run_phase(1'b0, 8'd0, 6, 32, 32, 0, 0);
        run_phase(1'b1, 8'd0, 6, 32, 32, 0, 0);
        // +8: step 264, 1000 symbols span ceil(8192000/264)=31031.
        run_phase(1'b0, 8'd8, 1001, 31, 32, 31029, 31031);
        // -8: step 248, intervals floor/ceil(33.03), span ceil(8192000/248)=33033.
        run_phase(1'b0, 8'hF8, 1001, 33, 34, 33031, 33033);

        // Underrun across one boundary, then recovery, then reset mid-symbol.
        zs    = 1'b0;
        drift = 8'd0;
        do_reset();
        run_syms(2, 200);
        @(negedge clk);
        check("ur_strobe", strobe, 1'b1);
        repeat (30) @(negedge clk);
        check("ur_ready_mid", ready, 1'b0);
        @(negedge clk);
        check("ur_ready_boundary", ready, 1'b1);
        check("ur_before", und, 1'b0);
        @(negedge clk);
        check("ur_set", und, 1'b1);
        check("ur_I", i_out, '0);
        check("ur_Q", q_out, '0);
        check("ur_strobe_low", strobe, 1'b0);
        check("ur_ready_idle", ready, 1'b1);
        repeat (5) @(negedge clk);
        check("ur_sticky_idle", und, 1'b1);
        check("ur_idle_I", i_out, '0);
        @(posedge clk);
        #1;
        per_lo     = 32;
        per_hi     = 32;
        chk_period = 1;
        run_syms(3, 200);
        @(negedge clk);
        check("ur_restart_strobe", strobe, 1'b1);
        check("ur_sticky_run", und, 1'b1);
        repeat (10) @(negedge clk);
        chk_period = 0;
        check("ur_sb_empty", sb.size(), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_underrun", und, 1'b0);
        check("rst_I", i_out, '0);
        check("rst_Q", q_out, '0);
        check("rst_strobe", strobe, 1'b0);
        check("rst_ready", ready, 1'b1);
        $display("underrun/reset sequence done at cycle %0d", cyc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation still running at cycle %0d, expected finish", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
